// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Build option: SWEEPER_GRAY_ORDER_EN (see tts_vec_gen).
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int CNT_W = 8;

    function automatic int numVectors(input int nIn);
        return 1 << nIn;
    endfunction

endpackage

// File: rtl/tts_vec_gen.sv
// Input-vector generator: walks a step index and presents the matching stimulus.
// Build option: SWEEPER_GRAY_ORDER_EN selects reflected Gray order instead of binary ascending.
module tts_vec_gen
    import tts_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            advance_i,
    output logic [N_IN-1:0] stim_o,
    output logic            last_o
);

    localparam int N_VEC = numVectors(N_IN);

    logic [N_IN-1:0] step_q, step_d;
    logic [N_IN-1:0] stim_q, stim_d;

    // stim is kept as its own register so the Gray conversion never glitches the DUT inputs
    always_comb begin
        step_d = step_q;
        stim_d = stim_q;
        if (clear_i) begin
            step_d = '0;
            stim_d = '0;
        end else if (advance_i) begin
            step_d = step_q + 1'b1;
`ifdef SWEEPER_GRAY_ORDER_EN
            stim_d = step_d ^ (step_d >> 1);
`else
            stim_d = step_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_q <= '0;
            stim_q <= '0;
        end else begin
            step_q <= step_d;
            stim_q <= stim_d;
        end
    end

    assign stim_o = stim_q;
    assign last_o = (step_q == N_IN'(N_VEC - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector through a bank of structural/behavioural function pairs,
// capturing truth tables and mismatches. Build option: SWEEPER_GRAY_ORDER_EN (vector order).
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int N_FUNC        = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    output logic [N_IN-1:0]                stim,
    input  logic [N_FUNC-1:0]              dut_out,
    input  logic [N_FUNC-1:0]              ref_out,
    output logic                           busy,
    output logic                           done,
    output logic [N_FUNC*numVectors(N_IN)-1:0] table_out,
    output logic [N_FUNC-1:0]              mismatch_mask,
    output logic [N_IN-1:0]                first_fail_vec,
    output logic                           pass
);

    localparam int                N_VEC      = numVectors(N_IN);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       pass_q, pass_d;
    logic [N_FUNC*N_VEC-1:0]    table_q, table_d;
    logic [N_FUNC-1:0]          mask_q, mask_d;
    logic [N_IN-1:0]            ffv_q, ffv_d;

    logic                       vgClear, vgAdvance, lastVec;
    logic [N_IN-1:0]            stimVec;
    logic [N_FUNC-1:0]          newMis;

    tts_vec_gen #(.N_IN(N_IN)) uVecGen (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (vgClear),
        .advance_i(vgAdvance),
        .stim_o   (stimVec),
        .last_o   (lastVec)
    );

    assign newMis = dut_out ^ ref_out;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        table_d   = table_q;
        mask_d    = mask_q;
        ffv_d     = ffv_q;
        vgClear   = 1'b0;
        vgAdvance = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    table_d = '0;
                    mask_d  = '0;
                    ffv_d   = '0;
                    pass_d  = 1'b0;
                    vgClear = 1'b1;
                    cnt_d   = CNT_RELOAD;
                    busy_d  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    vgClear = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                // abort outranks capture so a cancelled vector never lands in the table
                if (abort) begin
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    vgClear = 1'b1;
                    state_d = IDLE;
                end else begin
                    for (int f = 0; f < N_FUNC; f++) begin
                        for (int v = 0; v < N_VEC; v++) begin
                            if (stimVec == N_IN'(v)) begin
                                table_d[f*N_VEC + v] = dut_out[f];
                            end
                        end
                    end
                    mask_d = mask_q | newMis;
                    if ((mask_q == '0) && (newMis != '0)) begin
                        ffv_d = stimVec;
                    end
                    if (lastVec) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (mask_d == '0);
                        state_d = DONE;
                    end else begin
                        vgAdvance = 1'b1;
                        cnt_d     = CNT_RELOAD;
                        state_d   = SETTLE;
                    end
                end
            end
            DONE: begin
                vgClear = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            table_q <= '0;
            mask_q  <= '0;
            ffv_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            table_q <= table_d;
            mask_q  <= mask_d;
            ffv_q   <= ffv_d;
        end
    end

    assign stim           = stimVec;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign table_out      = table_q;
    assign mismatch_mask  = mask_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper using f = ((A&B)|~C)^(~B|C) as the function pair.
// Expected vector order follows SWEEPER_GRAY_ORDER_EN when it is defined.
module tb_truth_table_sweeper;

    localparam int MAX_E = 34;

    logic        clk = 1'b0;
    logic        rst, start, abort, faultEn;
    logic [2:0]  stim;
    logic [0:0]  dutOut, refOut;
    logic        busy, done, pass;
    logic [7:0]  tableOut;
    logic [0:0]  mismatchMask;
    logic [2:0]  firstFailVec;

    int          nCompared = 0;
    int          nMismatched = 0;

    logic [2:0]  expOrder [8];
    logic [2:0]  seqObs [8];
    int          edgesToDone, doneCount;
    logic [7:0]  tableAtDone;
    logic [0:0]  maskAtDone;
    logic [2:0]  ffvAtDone;
    logic        passAtDone, passAfterStart, busyMid, busyAfterAbort;
    logic [17:0] allAfterRst;
    logic [7:0]  goldTable, partialTable;

    truth_table_sweeper #(.N_IN(3), .N_FUNC(1), .SETTLE_CYCLES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .stim          (stim),
        .dut_out       (dutOut),
        .ref_out       (refOut),
        .busy          (busy),
        .done          (done),
        .table_out     (tableOut),
        .mismatch_mask (mismatchMask),
        .first_fail_vec(firstFailVec),
        .pass          (pass)
    );

    always #5 clk = ~clk;

    function automatic logic refFunc(input logic [2:0] v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return ((a & b) | ~c) ^ (~b | c);
    endfunction

    // The structural copy can be made faulty at vector 5 only
    assign refOut[0] = refFunc(stim);
    assign dutOut[0] = refFunc(stim) ^ (faultEn && (stim == 3'd5));

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One sweep; optional extra start, abort or reset at the given edge number after the start edge
    task automatic applyStimulus(input int startAgainAt, input int abortAt, input int rstAt);
        edgesToDone = -1;
        doneCount   = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seqObs[0]      = stim;
        passAfterStart = pass;
        for (int e = 1; e <= MAX_E; e++) begin
            start = (e == startAgainAt);
            abort = (e == abortAt);
            rst   = (e == rstAt);
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            if (done) begin
                doneCount++;
                if (edgesToDone < 0) begin
                    edgesToDone = e;
                    tableAtDone = tableOut;
                    maskAtDone  = mismatchMask;
                    ffvAtDone   = firstFailVec;
                    passAtDone  = pass;
                end
            end
            if ((e % 3 == 0) && (e < 24)) seqObs[e/3] = stim;
            if (e == 12) busyMid = busy;
            if (e == abortAt) busyAfterAbort = busy;
            if (e == rstAt) allAfterRst = {stim, busy, done, tableOut, mismatchMask, firstFailVec, pass};
        end
    endtask

    initial begin
`ifdef SWEEPER_GRAY_ORDER_EN
        expOrder = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
        expOrder = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
        goldTable    = 8'h6E;
        partialTable = '0;
        for (int k = 0; k < 3; k++) partialTable[expOrder[k]] = goldTable[expOrder[k]];

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        faultEn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_stim", stim, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_table", tableOut, 0);
        checkOutput("rst_mask", mismatchMask, 0);
        checkOutput("rst_ffv", firstFailVec, 0);
        checkOutput("rst_pass", pass, 0);
        rst = 1'b0;

        $display("[TB] loopback sweep");
        applyStimulus(0, 0, 0);
        checkOutput("loop_latency", edgesToDone, 24);
        checkOutput("loop_done_count", doneCount, 1);
        checkOutput("loop_table", tableAtDone, 8'h6E);
        checkOutput("loop_mask", maskAtDone, 0);
        checkOutput("loop_ffv", ffvAtDone, 0);
        checkOutput("loop_pass", passAtDone, 1);
        checkOutput("loop_busy_mid", busyMid, 1);
        checkOutput("loop_busy_after", busy, 0);
        checkOutput("loop_pass_held", pass, 1);
        checkOutput("loop_stim_idle", stim, 0);
        for (int k = 0; k < 8; k++) checkOutput($sformatf("loop_stim%0d", k), seqObs[k], expOrder[k]);

        $display("[TB] fault at vector 5");
        faultEn = 1'b1;
        applyStimulus(0, 0, 0);
        faultEn = 1'b0;
        checkOutput("fault_pass_cleared", passAfterStart, 0);
        checkOutput("fault_latency", edgesToDone, 24);
        checkOutput("fault_table", tableAtDone, 8'h4E);
        checkOutput("fault_mask", maskAtDone, 1);
        checkOutput("fault_ffv", ffvAtDone, 5);
        checkOutput("fault_pass", passAtDone, 0);

        $display("[TB] start repeated mid-sweep");
        applyStimulus(10, 0, 0);
        checkOutput("restart_latency", edgesToDone, 24);
        checkOutput("restart_done_count", doneCount, 1);
        checkOutput("restart_table", tableAtDone, 8'h6E);
        checkOutput("restart_pass", passAtDone, 1);
        for (int k = 0; k < 8; k++) checkOutput($sformatf("restart_stim%0d", k), seqObs[k], expOrder[k]);

        $display("[TB] abort during SAMPLE of fourth vector");
        applyStimulus(0, 12, 0);
        checkOutput("abort_busy", busyAfterAbort, 0);
        checkOutput("abort_done_count", doneCount, 0);
        checkOutput("abort_pass", pass, 0);
        checkOutput("abort_table", tableOut, partialTable);
        checkOutput("abort_mask", mismatchMask, 0);
        applyStimulus(0, 0, 0);
        checkOutput("post_abort_latency", edgesToDone, 24);
        checkOutput("post_abort_table", tableAtDone, 8'h6E);
        checkOutput("post_abort_pass", passAtDone, 1);

        $display("[TB] reset mid-sweep");
        applyStimulus(0, 0, 15);
        checkOutput("midrst_outputs", allAfterRst, 0);
        checkOutput("midrst_done_count", doneCount, 0);
        checkOutput("midrst_busy_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
